// File: rtl/plic_pkg.sv
// Shared types for the PLIC claim/complete path: source ID width, claim FSM
// states and a helper for index widths that stays legal for a single target.
package plic_pkg;

  localparam int SRC_ID_W = 5;

  typedef logic [SRC_ID_W-1:0] src_id_t;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    SETTLE
  } claim_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plic_claim_ctrl_if.sv
// Signals between the register interface / routing array / gateways and the
// claim controller. The controller uses the slave modport.
interface plic_claim_ctrl_if
  import plic_pkg::*;
#(
  parameter int SRC_N = 1,
  parameter int TGT_N = 1
);

  logic [TGT_N-1:0][SRC_ID_W-1:0] max_src;
  logic [TGT_N-1:0]               claim_req;
  logic [TGT_N-1:0]               claim_ack;
  src_id_t                        claim_id;
  logic [TGT_N-1:0]               complete_req;
  logic [TGT_N-1:0][SRC_ID_W-1:0] complete_id;
  logic [SRC_N:0]                 gw_claim;
  logic [SRC_N:0]                 gw_complete;
  logic [SRC_N:0]                 in_service;

  modport master (
    output max_src, claim_req, complete_req, complete_id,
    input  claim_ack, claim_id, gw_claim, gw_complete, in_service
  );

  modport slave (
    input  max_src, claim_req, complete_req, complete_id,
    output claim_ack, claim_id, gw_claim, gw_complete, in_service
  );

endinterface

// File: rtl/plic_rr_arbiter.sv
// Round-robin arbiter: search starts one above the last granted index; the
// pointer moves to the granted index only when en is high.
module plic_rr_arbiter #(
  parameter int N     = 1,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [IDX_W-1:0] ptr_reg;

  always_comb begin
    grant     = '0;
    grant_idx = ptr_reg;
    valid     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(ptr_reg) + k) % N);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_reg <= IDX_W'(N - 1);
    end else if (en && valid) begin
      ptr_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/plic_claim_ctrl.sv
// PLIC claim/complete sequencer: one shared claim path arbitrated over targets,
// in-service tracking and validated completion. Macro: PLIC_CLAIM_OWNER_CHECK_EN.
module plic_claim_ctrl
  import plic_pkg::*;
#(
  parameter int SRC_N = 1,
  parameter int TGT_N = 1
) (
  input logic              clk,
  input logic              rstn,
  plic_claim_ctrl_if.slave bus
);

  localparam int TGT_W = idx_w(TGT_N);

  claim_state_e     state_reg, state_next;
  src_id_t          id_reg, id_next;
  src_id_t          sel_id;
  logic [TGT_N-1:0] grant;
  logic [TGT_W-1:0] grant_idx;
  logic             grant_valid;
  logic             grant_en;
  logic [TGT_N-1:0] claim_ack_reg;
  src_id_t          claim_id_reg;
  logic [SRC_N:0]   gw_claim_reg, gw_claim_next;
  logic [SRC_N:0]   gw_complete_reg;
  logic [SRC_N:0]   in_service_reg, in_service_next;
  logic [SRC_N:0]   set_mask, clear_mask;

  assign grant_en = (state_reg == IDLE) && grant_valid;
  assign sel_id   = bus.max_src[grant_idx];

  plic_rr_arbiter #(
    .N    (TGT_N),
    .IDX_W(TGT_W)
  ) u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (bus.claim_req),
    .en       (grant_en),
    .grant    (grant),
    .grant_idx(grant_idx),
    .valid    (grant_valid)
  );

  // SETTLE gives the gateway's pending clear time to reach max_src.
  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      IDLE: begin
        if (grant_en) begin
          id_next    = sel_id;
          state_next = RESP;
        end
      end
      RESP:    state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef PLIC_CLAIM_OWNER_CHECK_EN
  logic [TGT_W-1:0] tgt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tgt_reg <= '0;
    end else if (grant_en) begin
      tgt_reg <= grant_idx;
    end
  end
`endif

  assign set_mask[0]      = 1'b0;
  assign clear_mask[0]    = 1'b0;
  assign gw_claim_next[0] = 1'b0;

  for (genvar gi = 1; gi <= SRC_N; gi++) begin : g_src
    logic [TGT_N-1:0] hit;

`ifdef PLIC_CLAIM_OWNER_CHECK_EN
    logic [TGT_W-1:0] owner_reg;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        owner_reg <= '0;
      end else if (set_mask[gi]) begin
        owner_reg <= tgt_reg;
      end
    end
`endif

    for (genvar gt = 0; gt < TGT_N; gt++) begin : g_tgt
      assign hit[gt] = bus.complete_req[gt]
                    && (bus.complete_id[gt] == src_id_t'(gi))
                    && in_service_reg[gi]
`ifdef PLIC_CLAIM_OWNER_CHECK_EN
                    && (owner_reg == TGT_W'(gt))
`endif
                    ;
    end

    // Several targets hitting the same source collapse into one pulse.
    assign clear_mask[gi]    = |hit;
    assign set_mask[gi]      = (state_reg == RESP) && (id_reg == src_id_t'(gi));
    assign gw_claim_next[gi] = grant_en && (sel_id == src_id_t'(gi));
  end

  // A claim landing on a source being completed in the same cycle wins.
  assign in_service_next = (in_service_reg & ~clear_mask) | set_mask;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      id_reg          <= '0;
      claim_ack_reg   <= '0;
      claim_id_reg    <= '0;
      gw_claim_reg    <= '0;
      gw_complete_reg <= '0;
      in_service_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      id_reg          <= id_next;
      claim_ack_reg   <= grant_en ? grant : '0;
      claim_id_reg    <= grant_en ? sel_id : '0;
      gw_claim_reg    <= gw_claim_next;
      gw_complete_reg <= clear_mask;
      in_service_reg  <= in_service_next;
    end
  end

  assign bus.claim_ack   = claim_ack_reg;
  assign bus.claim_id    = claim_id_reg;
  assign bus.gw_claim    = gw_claim_reg;
  assign bus.gw_complete = gw_complete_reg;
  assign bus.in_service  = in_service_reg;

endmodule

// File: doc/plic_claim_ctrl.md
# plic_claim_ctrl

Per-target claim/complete sequencer of the PLIC, sitting between the routing array (per-target highest-priority source), the gateways (pending clear / re-arm) and the register interface (claim/complete register accesses). Shares the single claim path among all targets with a round-robin arbiter, so no source is claimed by two targets. Tracks which sources are in service and validates completions before re-arming the gateway.

## Interface
- SRC_N, 1, number of interrupt sources (source 0 reserved, "no interrupt"); SRC_N ≤ 31
- TGT_N, 1, number of targets (contexts)
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- max_src  in  [TGT_N-1:0][4:0]  per-target highest-priority pending enabled source ID (0 = none)
- claim_req  in  [TGT_N-1:0]  claim register read request; held high until acked
- claim_ack  out  [TGT_N-1:0]  one-cycle acknowledge, one-hot or zero
- claim_id  out  5  claimed source ID, valid while any claim_ack bit is high
- complete_req  in  [TGT_N-1:0]  claim register write strobe (single cycle)
- complete_id  in  [TGT_N-1:0][4:0]  written source ID per target
- gw_claim  out  [SRC_N:0]  one-cycle pulse: gateway clears pending for that source
- gw_complete  out  [SRC_N:0]  one-cycle pulse: gateway re-arms that source
- in_service  out  [SRC_N:0]  sources claimed and not yet completed

## Operation
- Claim FSM, states IDLE, RESP, SETTLE:
  - IDLE: if any claim_req bit, round-robin arbiter picks target g (search starts one above last granted); latch g and max_src[g]; -> RESP. Else stay.
  - RESP: claim_ack[g]=1, claim_id=latched ID; if ID≠0, gw_claim[ID]=1 and in_service[ID] set at end of cycle; -> SETTLE.
  - SETTLE: no outputs; lets the gateway pending clear propagate through routing array; -> IDLE.
- Latched ID 0: ack still given with claim_id=0; no gw_claim, no in_service change.
- Round-robin pointer updates to g on every grant (including ID 0).
- Completion, independent of FSM state, every cycle, all targets in parallel:
  - accepted if complete_req[t], 1 ≤ complete_id[t] ≤ SRC_N, in_service[id] set (plus owner check, see Configuration).
  - accepted: gw_complete[id] pulse next cycle, in_service[id] cleared at end of request cycle.
  - invalid completions silently ignored; two targets completing same ID same cycle -> one pulse.
- Claim set and completion clear of the same source in the same cycle: set wins.
- claim_req dropped before ack: grant already latched still completes its RESP (register interface must hold).

## Timing
- Reset values: claim_ack=0, claim_id=0, gw_claim=0, gw_complete=0, in_service=0, FSM=IDLE, RR pointer=TGT_N-1 (target 0 first).
- claim_req high in IDLE at cycle N -> claim_ack at N+1; next grant earliest N+3 (throughput one claim per 3 cycles).
- complete_req at cycle N -> gw_complete pulse at N+1; in_service bit low from N+1.
- All outputs registered. Reset mid-operation aborts any grant with no ack issued.

## Configuration
- PLIC_CLAIM_OWNER_CHECK_EN defined: per-source owner register (target index, clog2(TGT_N) bits) written at claim; completion accepted only from the owning target; wrong-target completion ignored.
- Not defined: no owner storage; any target completing an in-service ID releases it.

## Structure
- plic_pkg: SRC_ID_W=5, claim FSM state enum (IDLE, RESP, SETTLE), source ID typedef.
- Sub-module plic_rr_arbiter (TGT_N requests, one-hot grant, pointer advanced on an enable input).

## Test plan
- Target 0 claim, max_src[0]=3 -> claim_ack[0] at +1, claim_id=3, gw_claim[3] pulse, in_service[3]=1.
- Targets 0 and 1 request together, both max_src=5 then 0 after clear -> tgt0 gets 5, tgt1 acked 3 cycles later with 0; no second gw_claim.
- Three targets held requesting continuously -> grants in order 0,1,2,0 at 3-cycle spacing.
- Complete ID 3 by target 0 after claim -> gw_complete[3] at +1, in_service[3]=0; repeat complete -> ignored; complete ID 0 or 31 (SRC_N=7) -> ignored.
- With PLIC_CLAIM_OWNER_CHECK_EN: target 1 completes ID 3 owned by target 0 -> ignored; without macro -> accepted.
- Assert rstn low during RESP -> no ack, all outputs 0, in_service cleared; post-reset claim works.
